// File: rtl/cc_mem_arbiter.sv
// cc_mem_arbiter: shares one word-wide memory port between the instruction-side
// (cc0) and data-side (cc1) cache controllers. One-cycle miss pulses are buffered,
// granted round-robin, and served as WORD_NUM-beat critical-word-first line fills
// whose per-beat word address wraps inside the line.
module cc_mem_arbiter #(
    parameter int ADR_WIDTH         = 32,
    parameter int WORD_WIDTH        = 32,
    parameter int WORD_NUM          = 4,
    parameter int WORD_OFFSET_WIDTH = 2,
    parameter int BYTE_OFFSET_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_cc02arb,
    input  logic [ADR_WIDTH-1:0]  adr_cc02arb,
    output logic                  ack_arb2cc0,
    output logic [WORD_WIDTH-1:0] dat_arb2cc0,
    input  logic                  req_cc12arb,
    input  logic [ADR_WIDTH-1:0]  adr_cc12arb,
    output logic                  ack_arb2cc1,
    output logic [WORD_WIDTH-1:0] dat_arb2cc1,
    output logic                  req_arb2mem,
    output logic [ADR_WIDTH-1:0]  adr_arb2mem,
    input  logic                  ack_mem2arb,
    input  logic [WORD_WIDTH-1:0] dat_mem2arb,
    output logic                  grant_id,
    output logic                  busy,
    output logic                  err_flag
);

    localparam int LINE_LSB = BYTE_OFFSET_WIDTH + WORD_OFFSET_WIDTH;
    localparam logic [WORD_OFFSET_WIDTH-1:0] LAST_BEAT = WORD_OFFSET_WIDTH'(WORD_NUM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t                             state_q, state_d;
    logic                               pend0_q, pend0_d, pend1_q, pend1_d;
    logic [ADR_WIDTH-1:0]               adr0_q, adr0_d, adr1_q, adr1_d;
    logic [ADR_WIDTH-LINE_LSB-1:0]      tag_q, tag_d;
    logic [WORD_OFFSET_WIDTH-1:0]       w0_q, w0_d, beat_q, beat_d;
    logic                               grant_q, grant_d, prio_q, prio_d, err_q, err_d;

    logic                               sel;
    logic [ADR_WIDTH-1:0]               sel_adr;
    logic [WORD_OFFSET_WIDTH-1:0]       cur_word;
    logic                               fwd;
    logic                               unused_byte_bits;

    // With both requests pending the priority pointer decides, otherwise the lone requester wins
    assign sel      = (pend0_q && pend1_q) ? prio_q : pend1_q;
    assign sel_adr  = sel ? adr1_q : adr0_q;
    assign unused_byte_bits = ^sel_adr[BYTE_OFFSET_WIDTH-1:0];

    // Word index wraps modulo WORD_NUM through the natural width of the adder
    assign cur_word    = w0_q + beat_q;
    assign adr_arb2mem = {tag_q, cur_word, {BYTE_OFFSET_WIDTH{1'b0}}};
    assign req_arb2mem = (state_q == ISSUE);
    assign busy        = (state_q != IDLE);
    assign grant_id    = grant_q;
    assign err_flag    = err_q;

    // Memory beats are only steered while a fill is active and never during reset
    assign fwd         = rst && ack_mem2arb && (state_q != IDLE);
    assign ack_arb2cc0 = fwd && !grant_q;
    assign ack_arb2cc1 = fwd && grant_q;
    assign dat_arb2cc0 = ack_arb2cc0 ? dat_mem2arb : '0;
    assign dat_arb2cc1 = ack_arb2cc1 ? dat_mem2arb : '0;

    // Request capture, grant decision and fill progress
    always_comb begin
        state_d = state_q;
        pend0_d = pend0_q;
        pend1_d = pend1_q;
        adr0_d  = adr0_q;
        adr1_d  = adr1_q;
        tag_d   = tag_q;
        w0_d    = w0_q;
        beat_d  = beat_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        err_d   = err_q;

        // A second pulse while the first is still outstanding is a controller bug: keep the first
        if (req_cc02arb) begin
            if (pend0_q) err_d = 1'b1;
            else begin
                pend0_d = 1'b1;
                adr0_d  = adr_cc02arb;
            end
        end
        if (req_cc12arb) begin
            if (pend1_q) err_d = 1'b1;
            else begin
                pend1_d = 1'b1;
                adr1_d  = adr_cc12arb;
            end
        end

        case (state_q)
            IDLE: begin
                if (ack_mem2arb) err_d = 1'b1;
                if (pend0_q || pend1_q) begin
                    grant_d = sel;
                    tag_d   = sel_adr[ADR_WIDTH-1:LINE_LSB];
                    w0_d    = sel_adr[BYTE_OFFSET_WIDTH +: WORD_OFFSET_WIDTH];
                    beat_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE, BURST: begin
                if (state_q == ISSUE) state_d = BURST;
                if (ack_mem2arb) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        if (grant_q) pend1_d = 1'b0;
                        else         pend0_d = 1'b0;
                        prio_d  = !grant_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and fill-position registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            pend0_q <= 1'b0;
            pend1_q <= 1'b0;
            tag_q   <= '0;
            w0_q    <= '0;
            beat_q  <= '0;
            grant_q <= 1'b0;
            prio_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend0_q <= pend0_d;
            pend1_q <= pend1_d;
            tag_q   <= tag_d;
            w0_q    <= w0_d;
            beat_q  <= beat_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
            err_q   <= err_d;
        end
    end

    // Latched miss addresses; only meaningful while the matching pending flag is set
    always_ff @(posedge clk) begin
        adr0_q <= adr0_d;
        adr1_q <= adr1_d;
    end

endmodule

// File: tb/tb_cc_mem_arbiter.sv
// Bench for cc_mem_arbiter: the testbench plays both cache controllers and the
// memory, and predicts grants and beat addresses from the arbitration rules.
`timescale 1ns/1ps
module tb_cc_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_cc02arb = 1'b0;
    logic [31:0] adr_cc02arb = '0;
    logic        ack_arb2cc0;
    logic [31:0] dat_arb2cc0;
    logic        req_cc12arb = 1'b0;
    logic [31:0] adr_cc12arb = '0;
    logic        ack_arb2cc1;
    logic [31:0] dat_arb2cc1;
    logic        req_arb2mem;
    logic [31:0] adr_arb2mem;
    logic        ack_mem2arb = 1'b0;
    logic [31:0] dat_mem2arb = '0;
    logic        grant_id;
    logic        busy;
    logic        err_flag;

    int checks = 0;
    int errors = 0;

    // Reference model state: outstanding request per controller
    logic        m_pend0, m_pend1;
    logic [31:0] m_adr0, m_adr1;

    cc_mem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_cc02arb (req_cc02arb),
        .adr_cc02arb (adr_cc02arb),
        .ack_arb2cc0 (ack_arb2cc0),
        .dat_arb2cc0 (dat_arb2cc0),
        .req_cc12arb (req_cc12arb),
        .adr_cc12arb (adr_cc12arb),
        .ack_arb2cc1 (ack_arb2cc1),
        .dat_arb2cc1 (dat_arb2cc1),
        .req_arb2mem (req_arb2mem),
        .adr_arb2mem (adr_arb2mem),
        .ack_mem2arb (ack_mem2arb),
        .dat_mem2arb (dat_mem2arb),
        .grant_id    (grant_id),
        .busy        (busy),
        .err_flag    (err_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Word address of beat k of a critical-word-first fill starting at line
    function automatic logic [31:0] exp_addr(input logic [31:0] line, input int k);
        logic [31:0] word;
        word = ((line >> 2) + 32'(k)) % 32'd4;
        return (line & 32'hFFFF_FFF0) | (word << 2);
    endfunction

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b0; req_cc02arb = 1'b0; req_cc12arb = 1'b0; ack_mem2arb = 1'b0; dat_mem2arb = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic pulse(input logic b0, input logic [31:0] a0, input logic b1, input logic [31:0] a1);
        @(posedge clk); #1;
        req_cc02arb = b0; adr_cc02arb = a0;
        req_cc12arb = b1; adr_cc12arb = a1;
        @(posedge clk); #1;
        req_cc02arb = 1'b0; req_cc12arb = 1'b0;
    endtask

    task automatic wait_issue(output int lat, output bit found);
        found = 1'b0;
        lat   = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (req_arb2mem === 1'b1) begin
                lat   = n;
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL issue_timeout: req_arb2mem got 0 for 20 cycles, required 1");
        end
    endtask

    // Entered at the falling edge of the ISSUE cycle; plays memory for one fill
    task automatic serve_burst(input logic gid, input logic [31:0] line, input int gap, input string tag);
        logic [31:0] d, ea, dg, dn;
        logic ag, an;
        checks++;
        if (adr_arb2mem !== exp_addr(line, 0)) begin
            errors++;
            $display("FAIL %s issue_adr: got %h required %h", tag, adr_arb2mem, exp_addr(line, 0));
        end
        checks++;
        if (grant_id !== gid || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s issue_grant: got grant=%b busy=%b required grant=%b busy=1", tag, grant_id, busy, gid);
        end
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                ack_mem2arb = 1'b0;
                @(negedge clk);
                checks++;
                if (ack_arb2cc0 !== 1'b0 || ack_arb2cc1 !== 1'b0) begin
                    errors++;
                    $display("FAIL %s gap_ack: got %b%b required 00", tag, ack_arb2cc1, ack_arb2cc0);
                end
            end
            @(posedge clk); #1;
            d = $urandom;
            ack_mem2arb = 1'b1;
            dat_mem2arb = d;
            @(negedge clk);
            ea = exp_addr(line, k);
            ag = gid ? ack_arb2cc1 : ack_arb2cc0;
            an = gid ? ack_arb2cc0 : ack_arb2cc1;
            dg = gid ? dat_arb2cc1 : dat_arb2cc0;
            dn = gid ? dat_arb2cc0 : dat_arb2cc1;
            checks++;
            if (adr_arb2mem !== ea || req_arb2mem !== 1'b0) begin
                errors++;
                $display("FAIL %s beat%0d_adr: got adr=%h req=%b required adr=%h req=0", tag, k, adr_arb2mem, req_arb2mem, ea);
            end
            checks++;
            if (ag !== 1'b1 || dg !== d) begin
                errors++;
                $display("FAIL %s beat%0d_fwd: got ack=%b dat=%h required ack=1 dat=%h", tag, k, ag, dg, d);
            end
            checks++;
            if (an !== 1'b0 || dn !== 32'h0) begin
                errors++;
                $display("FAIL %s beat%0d_other: got ack=%b dat=%h required ack=0 dat=0", tag, k, an, dn);
            end
        end
        @(posedge clk); #1;
        ack_mem2arb = 1'b0;
        dat_mem2arb = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req_arb2mem !== 1'b0) begin
            errors++;
            $display("FAIL %s bubble: got busy=%b req=%b required busy=0 req=0", tag, busy, req_arb2mem);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ack_mem2arb = 1'b1;
        dat_mem2arb = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || grant_id !== 1'b0 || err_flag !== 1'b0 || req_arb2mem !== 1'b0 || adr_arb2mem !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b grant=%b err=%b req=%b adr=%h required all 0",
                     busy, grant_id, err_flag, req_arb2mem, adr_arb2mem);
        end
        checks++;
        if (ack_arb2cc0 !== 1'b0 || ack_arb2cc1 !== 1'b0 || dat_arb2cc0 !== 32'h0 || dat_arb2cc1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b%b dat0=%h dat1=%h required zeros",
                     ack_arb2cc1, ack_arb2cc0, dat_arb2cc0, dat_arb2cc1);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        ack_mem2arb = 1'b0;
        dat_mem2arb = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (err_flag !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got err=%b busy=%b required 0 0", err_flag, busy);
        end
    endtask

    task automatic test_single();
        int lat; bit found;
        pulse(1'b1, 32'h0000_1238, 1'b0, 32'h0);
        wait_issue(lat, found);
        if (!found) return;
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL single_latency: got %0d required 2", lat);
        end
        serve_burst(1'b0, 32'h0000_1238, 0, "single");
    endtask

    task automatic test_simultaneous();
        int lat; bit found;
        apply_reset();
        pulse(1'b1, 32'h0000_0100, 1'b1, 32'h0000_2004);
        wait_issue(lat, found);
        if (!found) return;
        serve_burst(1'b0, 32'h0000_0100, 0, "simul_cc0");
        @(negedge clk);
        checks++;
        if (req_arb2mem !== 1'b1) begin
            errors++;
            $display("FAIL simul_bubble: got req=%b one cycle after bubble, required 1", req_arb2mem);
            return;
        end
        serve_burst(1'b1, 32'h0000_2004, 0, "simul_cc1");
    endtask

    task automatic test_spaced_acks();
        int lat; bit found;
        apply_reset();
        pulse(1'b1, 32'h0000_5678, 1'b0, 32'h0);
        wait_issue(lat, found);
        if (!found) return;
        fork
            serve_burst(1'b0, 32'h0000_5678, 2, "spaced_cc0");
            begin
                repeat (2) @(posedge clk);
                pulse(1'b0, 32'h0, 1'b1, 32'h0000_6ABC);
            end
        join
        @(negedge clk);
        checks++;
        if (req_arb2mem !== 1'b1 || err_flag !== 1'b0) begin
            errors++;
            $display("FAIL spaced_next: got req=%b err=%b two cycles after last ack, required req=1 err=0",
                     req_arb2mem, err_flag);
            return;
        end
        serve_burst(1'b1, 32'h0000_6ABC, 0, "spaced_cc1");
    endtask

    task automatic test_spurious_ack();
        @(posedge clk); #1;
        ack_mem2arb = 1'b1;
        dat_mem2arb = $urandom;
        @(negedge clk);
        checks++;
        if (ack_arb2cc0 !== 1'b0 || ack_arb2cc1 !== 1'b0 || dat_arb2cc0 !== 32'h0 || dat_arb2cc1 !== 32'h0) begin
            errors++;
            $display("FAIL spurious_fwd: got ack=%b%b dat0=%h dat1=%h required zeros",
                     ack_arb2cc1, ack_arb2cc0, dat_arb2cc0, dat_arb2cc1);
        end
        @(posedge clk); #1;
        ack_mem2arb = 1'b0;
        @(negedge clk);
        checks++;
        if (err_flag !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL spurious_err: got err=%b busy=%b required err=1 busy=0", err_flag, busy);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (err_flag !== 1'b1) begin
            errors++;
            $display("FAIL spurious_sticky: got err=%b required 1", err_flag);
        end
    endtask

    task automatic test_reset_mid_burst();
        int lat, seen; bit found;
        apply_reset();
        @(negedge clk);
        checks++;
        if (err_flag !== 1'b0) begin
            errors++;
            $display("FAIL midrst_errclear: got err=%b required 0", err_flag);
        end
        pulse(1'b0, 32'h0, 1'b1, 32'h0000_3008);
        wait_issue(lat, found);
        if (!found) return;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            ack_mem2arb = 1'b1;
            dat_mem2arb = $urandom;
            @(negedge clk);
            checks++;
            if (ack_arb2cc1 !== 1'b1 || adr_arb2mem !== exp_addr(32'h0000_3008, k)) begin
                errors++;
                $display("FAIL midrst_beat%0d: got ack=%b adr=%h required ack=1 adr=%h",
                         k, ack_arb2cc1, adr_arb2mem, exp_addr(32'h0000_3008, k));
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        dat_mem2arb = $urandom;
        @(negedge clk);
        checks++;
        if (ack_arb2cc0 !== 1'b0 || ack_arb2cc1 !== 1'b0 || dat_arb2cc1 !== 32'h0) begin
            errors++;
            $display("FAIL midrst_gate: got ack=%b%b dat1=%h during reset, required zeros",
                     ack_arb2cc1, ack_arb2cc0, dat_arb2cc1);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        ack_mem2arb = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req_arb2mem !== 1'b0 || grant_id !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: got busy=%b req=%b grant=%b required 0 0 0", busy, req_arb2mem, grant_id);
        end
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (req_arb2mem !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midrst_pend: got %0d active cycles after reset, required 0", seen);
        end
        pulse(1'b0, 32'h0, 1'b1, 32'h0000_3008);
        wait_issue(lat, found);
        if (!found) return;
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL midrst_latency: got %0d required 2", lat);
        end
        serve_burst(1'b1, 32'h0000_3008, 1, "midrst_fresh");
    endtask

    task automatic test_back_to_back();
        logic        last, g, alt;
        logic [31:0] na, nb, line;
        int          lat, gap, dly;
        bit          found, overlap;
        apply_reset();
        last = 1'b1;
        na = $urandom;
        nb = $urandom;
        m_pend0 = 1'b1; m_adr0 = na;
        m_pend1 = 1'b1; m_adr1 = nb;
        pulse(1'b1, na, 1'b1, nb);
        for (int r = 0; r < 6; r++) begin
            g    = (m_pend0 && m_pend1) ? !last : m_pend1;
            line = g ? m_adr1 : m_adr0;
            alt  = (r % 2 == 1);
            wait_issue(lat, found);
            if (!found) return;
            checks++;
            if (grant_id !== alt) begin
                errors++;
                $display("FAIL b2b_order%0d: got grant=%b required %b", r, grant_id, alt);
            end
            overlap = ($urandom_range(0, 1) == 1);
            gap     = $urandom_range(0, 2);
            dly     = $urandom_range(0, 2);
            na      = $urandom;
            if (overlap && !(g ? m_pend0 : m_pend1)) begin
                fork
                    serve_burst(g, line, gap, "b2b");
                    begin
                        repeat (dly) @(posedge clk);
                        pulse(g, na, !g, na);
                    end
                join
                if (g) begin m_pend0 = 1'b1; m_adr0 = na; end
                else   begin m_pend1 = 1'b1; m_adr1 = na; end
            end else begin
                serve_burst(g, line, gap, "b2b");
            end
            if (g) m_pend1 = 1'b0;
            else   m_pend0 = 1'b0;
            last = g;
            if (!m_pend0 && !m_pend1 && r < 5) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                na = $urandom;
                nb = $urandom;
                m_pend0 = 1'b1; m_adr0 = na;
                m_pend1 = 1'b1; m_adr1 = nb;
                pulse(1'b1, na, 1'b1, nb);
            end
        end
        checks++;
        if (err_flag !== 1'b0) begin
            errors++;
            $display("FAIL b2b_err: got err=%b required 0", err_flag);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_spaced_acks();
        test_spurious_ack();
        test_reset_mid_burst();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
